// File: rtl/reg_trace_multi.sv
// reg_trace_multi: 8-bit register window for the multi-rule trace trigger.
// Provides indexed pattern/mask access, enable banks, per-rule saturating
// hit counters and resync/commit strobes.
// Define REG_TRACE_MULTI_SHADOW_EN to stage pattern/mask/enable writes in
// shadow banks that are copied to the live outputs on COMMIT.
module reg_trace_multi #(
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pBUFFER_SIZE  = 64,
    parameter int unsigned pMATCH_RULES  = 16,
    parameter int unsigned pCOUNT_WIDTH  = 16,
    parameter logic [1:0]  pSELECT       = 2'b10
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_i,
    input  logic [7:0]                             reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    input  logic [7:0]                             write_data,
    output logic [7:0]                             read_data,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic                                   reg_addrvalid,
    output logic                                   selected,
    input  logic [pMATCH_RULES-1:0]                I_match_hit,
    input  logic                                   I_synchronized,
    input  logic [pBUFFER_SIZE-1:0]                I_matched_data,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_pattern,
    output logic [pMATCH_RULES*pBUFFER_SIZE-1:0]   O_trace_mask,
    output logic [pMATCH_RULES-1:0]                O_pattern_enable,
    output logic [pMATCH_RULES-1:0]                O_pattern_trig_enable,
    output logic [2:0]                             O_trace_width,
    output logic                                   O_capture_raw,
    output logic                                   O_commit_pulse,
    output logic                                   O_reset_sync
);

    localparam int unsigned cBufBytes = pBUFFER_SIZE / 8;
    localparam int unsigned cCntBytes = pCOUNT_WIDTH / 8;
    localparam int unsigned cEnBytes  = (pMATCH_RULES + 7) / 8;
    localparam int unsigned cBankBits = pMATCH_RULES * pBUFFER_SIZE;
    // "TraceMul" with 'T' in the least significant byte
    localparam logic [63:0] cName     = 64'h6C75_4D65_6361_7254;

    localparam logic [5:0] cOffName      = 6'h00;
    localparam logic [5:0] cOffRev       = 6'h01;
    localparam logic [5:0] cOffNumRules  = 6'h02;
    localparam logic [5:0] cOffIndex     = 6'h03;
    localparam logic [5:0] cOffPattern   = 6'h04;
    localparam logic [5:0] cOffMask      = 6'h05;
    localparam logic [5:0] cOffCount     = 6'h06;
    localparam logic [5:0] cOffClearAll  = 6'h07;
    localparam logic [5:0] cOffEnable    = 6'h08;
    localparam logic [5:0] cOffTrigEn    = 6'h09;
    localparam logic [5:0] cOffCommit    = 6'h0A;
    localparam logic [5:0] cOffResetSync = 6'h0B;
    localparam logic [5:0] cOffWidth     = 6'h0C;
    localparam logic [5:0] cOffRaw       = 6'h0D;
    localparam logic [5:0] cOffSync      = 6'h0E;
    localparam logic [5:0] cOffMatched   = 6'h0F;
    localparam logic [5:0] cOffStatus    = 6'h10;

    // Bus decode
    logic        w_wr;
    logic        w_rd;
    logic [5:0]  w_off;
    logic [31:0] w_bytecnt;
    logic [31:0] w_bit_base;
    logic [31:0] w_idx;
    logic [31:0] w_pat_base;
    logic        w_byte0;
    logic        w_idx_ok;
    logic        w_buf_ok;
    logic        w_cnt_ok;
    logic        w_en_ok;

    logic w_wr_index;
    logic w_wr_pattern;
    logic w_wr_mask;
    logic w_wr_count;
    logic w_wr_clear_all;
    logic w_wr_enable;
    logic w_wr_trig;
    logic w_wr_commit;
    logic w_wr_width;
    logic w_wr_raw;
    logic w_rs_strobe;
    logic w_rd_snap;

    // Control registers
    logic [7:0] r_rule_index;
    logic [2:0] r_trace_width;
    logic       r_capture_raw;
    logic       r_commit_pulse;
    logic       r_rs_prev;
    logic       r_reset_sync;
    logic [7:0] r_read_data;

    // Live configuration driving the matcher
    logic [cBankBits-1:0]    r_live_pattern;
    logic [cBankBits-1:0]    r_live_mask;
    logic [pMATCH_RULES-1:0] r_live_en;
    logic [pMATCH_RULES-1:0] r_live_trig;

    // Register-visible view of each bank and its byte-merged next value
    logic [cBankBits-1:0]    w_bank_pattern;
    logic [cBankBits-1:0]    w_bank_mask;
    logic [pMATCH_RULES-1:0] w_bank_en;
    logic [pMATCH_RULES-1:0] w_bank_trig;
    logic                    w_pending;
    logic [cBankBits-1:0]    w_pat_next;
    logic [cBankBits-1:0]    w_mask_next;
    logic [pMATCH_RULES-1:0] w_en_next;
    logic [pMATCH_RULES-1:0] w_trig_next;

    // Hit counters
    logic [pCOUNT_WIDTH-1:0] r_count [pMATCH_RULES];
    logic [pCOUNT_WIDTH-1:0] r_count_snap;
    logic [pCOUNT_WIDTH-1:0] w_cnt_sel;
    logic                    w_any_sat;
    logic [7:0]              w_read_byte;

    assign selected   = reg_addrvalid & (reg_address[7:6] == pSELECT);
    assign w_wr       = selected & reg_write;
    assign w_rd       = selected & reg_read;
    assign w_off      = reg_address[5:0];
    assign w_bytecnt  = 32'(reg_bytecnt);
    assign w_bit_base = w_bytecnt << 3;
    assign w_idx      = {24'd0, r_rule_index};
    assign w_pat_base = w_idx * pBUFFER_SIZE + w_bit_base;
    assign w_byte0    = (w_bytecnt == 32'd0);
    assign w_idx_ok   = (w_idx < pMATCH_RULES);
    assign w_buf_ok   = (w_bytecnt < cBufBytes);
    assign w_cnt_ok   = (w_bytecnt < cCntBytes);
    assign w_en_ok    = (w_bytecnt < cEnBytes);

    assign w_wr_index     = w_wr & (w_off == cOffIndex) & w_byte0;
    assign w_wr_pattern   = w_wr & (w_off == cOffPattern) & w_idx_ok & w_buf_ok;
    assign w_wr_mask      = w_wr & (w_off == cOffMask) & w_idx_ok & w_buf_ok;
    assign w_wr_count     = w_wr & (w_off == cOffCount) & w_idx_ok & w_cnt_ok;
    assign w_wr_clear_all = w_wr & (w_off == cOffClearAll) & w_byte0;
    assign w_wr_enable    = w_wr & (w_off == cOffEnable) & w_en_ok;
    assign w_wr_trig      = w_wr & (w_off == cOffTrigEn) & w_en_ok;
    assign w_wr_commit    = w_wr & (w_off == cOffCommit) & w_byte0;
    assign w_wr_width     = w_wr & (w_off == cOffWidth) & w_byte0;
    assign w_wr_raw       = w_wr & (w_off == cOffRaw) & w_byte0;
    assign w_rs_strobe    = w_wr & (w_off == cOffResetSync);
    assign w_rd_snap      = w_rd & (w_off == cOffCount) & w_idx_ok & w_byte0;

    // Replace one byte of a bank; bits shifted past the top fall away
    assign w_pat_next  = (w_bank_pattern & ~(cBankBits'(8'hFF) << w_pat_base))
                       | (cBankBits'(write_data) << w_pat_base);
    assign w_mask_next = (w_bank_mask & ~(cBankBits'(8'hFF) << w_pat_base))
                       | (cBankBits'(write_data) << w_pat_base);
    assign w_en_next   = (w_bank_en & ~(pMATCH_RULES'(8'hFF) << w_bit_base))
                       | (pMATCH_RULES'(write_data) << w_bit_base);
    assign w_trig_next = (w_bank_trig & ~(pMATCH_RULES'(8'hFF) << w_bit_base))
                       | (pMATCH_RULES'(write_data) << w_bit_base);

`ifdef REG_TRACE_MULTI_SHADOW_EN
    logic [cBankBits-1:0]    r_sh_pattern;
    logic [cBankBits-1:0]    r_sh_mask;
    logic [pMATCH_RULES-1:0] r_sh_en;
    logic [pMATCH_RULES-1:0] r_sh_trig;
    logic                    r_pending;
    logic                    w_cfg_write;

    assign w_cfg_write    = w_wr_pattern | w_wr_mask | w_wr_enable | w_wr_trig;
    assign w_bank_pattern = r_sh_pattern;
    assign w_bank_mask    = r_sh_mask;
    assign w_bank_en      = r_sh_en;
    assign w_bank_trig    = r_sh_trig;
    assign w_pending      = r_pending;

    // Shadow banks take register writes; pending tracks uncommitted edits
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_sh_pattern <= '0;
            r_sh_mask    <= '1;
            r_sh_en      <= '0;
            r_sh_trig    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_wr_pattern) r_sh_pattern <= w_pat_next;
            if (w_wr_mask)    r_sh_mask    <= w_mask_next;
            if (w_wr_enable)  r_sh_en      <= w_en_next;
            if (w_wr_trig)    r_sh_trig    <= w_trig_next;
            if (w_wr_commit) begin
                r_pending <= 1'b0;
            end else if (w_cfg_write) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Live banks copy every shadow bank on the same edge as the commit write
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_live_pattern <= '0;
            r_live_mask    <= '1;
            r_live_en      <= '0;
            r_live_trig    <= '0;
        end else if (w_wr_commit) begin
            r_live_pattern <= r_sh_pattern;
            r_live_mask    <= r_sh_mask;
            r_live_en      <= r_sh_en;
            r_live_trig    <= r_sh_trig;
        end
    end
`else
    assign w_bank_pattern = r_live_pattern;
    assign w_bank_mask    = r_live_mask;
    assign w_bank_en      = r_live_en;
    assign w_bank_trig    = r_live_trig;
    assign w_pending      = 1'b0;

    // Without shadow banks, register writes land directly in the live config
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_live_pattern <= '0;
            r_live_mask    <= '1;
            r_live_en      <= '0;
            r_live_trig    <= '0;
        end else begin
            if (w_wr_pattern) r_live_pattern <= w_pat_next;
            if (w_wr_mask)    r_live_mask    <= w_mask_next;
            if (w_wr_enable)  r_live_en      <= w_en_next;
            if (w_wr_trig)    r_live_trig    <= w_trig_next;
        end
    end
`endif

    // Control registers and single-cycle strobes
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_rule_index   <= 8'd0;
            r_trace_width  <= 3'd4;
            r_capture_raw  <= 1'b1;
            r_commit_pulse <= 1'b0;
            r_rs_prev      <= 1'b0;
            r_reset_sync   <= 1'b0;
        end else begin
            if (w_wr_index) r_rule_index  <= write_data;
            if (w_wr_width) r_trace_width <= write_data[2:0];
            if (w_wr_raw)   r_capture_raw <= write_data[0];
            r_commit_pulse <= w_wr_commit;
            r_rs_prev      <= w_rs_strobe;
            // Edge-detect so a held strobe gives a single pulse
            r_reset_sync   <= w_rs_strobe & ~r_rs_prev;
        end
    end

    // Saturating hit counters; any clear beats a coincident hit
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            for (int r = 0; r < int'(pMATCH_RULES); r++) begin
                r_count[r] <= '0;
            end
            r_count_snap <= '0;
        end else begin
            for (int r = 0; r < int'(pMATCH_RULES); r++) begin
                if (w_wr_clear_all || (w_wr_count && (w_idx == 32'(r)))) begin
                    r_count[r] <= '0;
                end else if (I_match_hit[r] && (r_count[r] != '1)) begin
                    r_count[r] <= r_count[r] + 1'b1;
                end
            end
            if (w_rd_snap) r_count_snap <= w_cnt_sel;
        end
    end

    // Select the indexed counter and flag saturation of any counter
    always_comb begin
        w_cnt_sel = '0;
        w_any_sat = 1'b0;
        for (int r = 0; r < int'(pMATCH_RULES); r++) begin
            if (w_idx == 32'(r)) w_cnt_sel = r_count[r];
            if (r_count[r] == '1) w_any_sat = 1'b1;
        end
    end

    // Read data mux for the addressed byte
    always_comb begin
        w_read_byte = 8'h00;
        case (w_off)
            cOffName:      if (w_bytecnt < 32'd8) w_read_byte = 8'(cName >> w_bit_base);
            cOffRev:       if (w_byte0) w_read_byte = 8'h02;
            cOffNumRules:  if (w_byte0) w_read_byte = 8'(pMATCH_RULES);
            cOffIndex:     if (w_byte0) w_read_byte = r_rule_index;
            cOffPattern:   if (w_idx_ok && w_buf_ok) w_read_byte = 8'(w_bank_pattern >> w_pat_base);
            cOffMask:      if (w_idx_ok && w_buf_ok) w_read_byte = 8'(w_bank_mask >> w_pat_base);
            cOffCount: begin
                // Byte 0 reads live and latches the snapshot for the upper bytes
                if (w_idx_ok && w_cnt_ok) begin
                    w_read_byte = w_byte0 ? w_cnt_sel[7:0] : 8'(r_count_snap >> w_bit_base);
                end
            end
            cOffEnable:    if (w_en_ok) w_read_byte = 8'(w_bank_en >> w_bit_base);
            cOffTrigEn:    if (w_en_ok) w_read_byte = 8'(w_bank_trig >> w_bit_base);
            cOffWidth:     if (w_byte0) w_read_byte = {5'd0, r_trace_width};
            cOffRaw:       if (w_byte0) w_read_byte = {7'd0, r_capture_raw};
            cOffSync:      if (w_byte0) w_read_byte = {7'd0, I_synchronized};
            cOffMatched:   if (w_buf_ok) w_read_byte = 8'(I_matched_data >> w_bit_base);
            cOffStatus:    if (w_byte0) w_read_byte = {6'd0, w_any_sat, w_pending};
            default:       w_read_byte = 8'h00;
        endcase
    end

    // Registered read data, zero whenever not a selected read
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            r_read_data <= 8'h00;
        end else begin
            r_read_data <= w_rd ? w_read_byte : 8'h00;
        end
    end

    assign read_data             = r_read_data;
    assign O_trace_pattern       = r_live_pattern;
    assign O_trace_mask          = r_live_mask;
    assign O_pattern_enable      = r_live_en;
    assign O_pattern_trig_enable = r_live_trig;
    assign O_trace_width         = r_trace_width;
    assign O_capture_raw         = r_capture_raw;
    assign O_commit_pulse        = r_commit_pulse;
    assign O_reset_sync          = r_reset_sync;

endmodule

// File: doc/reg_trace_multi.md
Name: reg_trace_multi

Overview:
Parametrised successor register block for the trace trigger. It supports any number of match rules through an indexed (window) register, shadow pattern/mask/enable banks with atomic commit, and per-rule saturating hit counters. It sits behind the USB register front-end on the same 8-bit register bus and drives the trace_trigger matcher configuration.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt
pBUFFER_SIZE, 64, pattern/mask width in bits (multiple of 8)
pMATCH_RULES, 16, number of match rules (1..64)
pCOUNT_WIDTH, 16, hit counter width in bits (multiple of 8, ≤64)
pSELECT, 2'b10, value of reg_address[7:6] that selects this block

Ports:
usb_clk  in  1  sole clock
reset_i  in  1  synchronous active-high reset
reg_address  in  8  register address
reg_bytecnt  in  pBYTECNT_SIZE  byte index within register
write_data  in  8  write byte
read_data  out  8  read byte, registered
reg_read / reg_write / reg_addrvalid  in  1 each  bus strobes
selected  out  1  reg_addrvalid & reg_address[7:6]==pSELECT (combinational)
I_match_hit  in  pMATCH_RULES  one-cycle hit pulse per rule, usb_clk domain
I_synchronized  in  1  trace synchronized status
I_matched_data  in  pBUFFER_SIZE  last matched data
O_trace_pattern / O_trace_mask  out  pMATCH_RULES*pBUFFER_SIZE each  live rules, rule r at [r*pBUFFER_SIZE +: pBUFFER_SIZE]
O_pattern_enable / O_pattern_trig_enable  out  pMATCH_RULES each  live enables
O_trace_width  out  3  lane count
O_capture_raw  out  1  raw capture mode
O_commit_pulse  out  1  one cycle, live config just updated
O_reset_sync  out  1  one-cycle resync pulse

Behaviour:
- Interface: one clock (usb_clk); reset (reset_i) is synchronous and active-high.
- Offsets (reg_address[5:0]):
  - 0x00 NAME, RO, 8 bytes ASCII "TraceMul", byte 0 = 'T'.
  - 0x01 REV, RO, 0x02.
  - 0x02 NUM_RULES, RO, pMATCH_RULES.
  - 0x03 RULE_INDEX, RW, 8 bits.
  - 0x04 PATTERN[idx], RW, shadow.
  - 0x05 MASK[idx], RW, shadow.
  - 0x06 COUNT[idx]: read = counter; write any value clears that counter.
  - 0x07 COUNT_CLEAR_ALL, WO.
  - 0x08 PATTERN_ENABLE, RW, shadow, bytecnt-indexed.
  - 0x09 PATTERN_TRIG_ENABLE, RW, shadow, bytecnt-indexed.
  - 0x0A COMMIT, WO.
  - 0x0B RESET_SYNC, WO.
  - 0x0C TRACE_WIDTH, RW, [2:0].
  - 0x0D CAPTURE_RAW, RW, [0].
  - 0x0E SYNCHRONIZED, RO.
  - 0x0F MATCHED_DATA, RO, bytecnt-indexed.
  - 0x10 STATUS, RO: bit0 = commit pending, bit1 = any counter saturated.
- Multi-byte access: byte b = bits [b*8 +: 8].
  - Byte beyond register width: write ignored, read 0.
  - RULE_INDEX ≥ pMATCH_RULES: indexed writes ignored, reads 0.
- Read path:
  - read_data registered; value valid the cycle after reg_read.
  - 0 when not selected or not reading; unmapped offsets read 0.
- Writes take effect on the usb_clk edge where selected & reg_write.
- Reset values:
  - shadow and live patterns 0; masks all ones; enables 0.
  - trace_width 4; capture_raw 1; RULE_INDEX 0; counters 0.
  - pending 0; O_commit_pulse 0; O_reset_sync 0; read_data 0.
- Commit:
  - A COMMIT write copies every shadow bank to live in a single edge, clears pending, and asserts O_commit_pulse for the next cycle (aligned with the new live values).
  - Pending is set by any PATTERN/MASK/ENABLE write.
  - Reads of those offsets return shadow, not live.
- Counters:
  - Rule r increments on I_match_hit[r] and saturates at all ones (no wrap).
  - Clear and hit in the same cycle: clear wins, result 0.
  - COUNT read snapshot: a read with bytecnt==0 latches the whole counter; bytes ≥1 return the snapshot, so a multi-byte read is tear-free.
- RESET_SYNC:
  - A rising edge of (selected & reg_write & addr==0x0B) gives O_reset_sync high for exactly one cycle.
  - A write strobe held for N cycles yields one pulse.
- reset_i asserted mid-operation (mid-commit, mid-read): all state returns to reset values on that edge; no pulse emitted.

Optional Feature:
- Macro REG_TRACE_MULTI_SHADOW_EN.
- Defined: shadow/commit behaviour as above.
- Undefined:
  - PATTERN/MASK/ENABLE writes update live directly.
  - COMMIT write still pulses O_commit_pulse one cycle.
  - STATUS bit0 reads 0.
  - Shadow storage is not instantiated.

Test Plan:
- Reset, then read: NAME byte0=0x54; REV=0x02; NUM_RULES=0x10; MASK[3] all bytes 0xFF; TRACE_WIDTH=4; each read value appears exactly one cycle after reg_read.
- RULE_INDEX=5, write PATTERN bytes 0..7 = 0x11..0x88 -> live rule5 still 0 and STATUS=0x01; COMMIT -> next cycle O_commit_pulse=1, live rule5=0x8877665544332211, STATUS=0x00.
- RULE_INDEX=16 (out of range), write PATTERN=0xAA -> no rule changes, PATTERN reads 0; write byte 8 of rule 0 -> ignored.
- 70000 hits on rule 2 (pCOUNT_WIDTH=16) -> COUNT reads 0xFFFF, STATUS bit1=1; COUNT_CLEAR_ALL in the same cycle as a hit -> counter 0.
- Counter at 0x00FF: read byte0 (0xFF), inject 1 hit, read byte1 -> 0x00 (snapshot), next full read -> 0x0100.
- RESET_SYNC write strobe held 3 cycles -> O_reset_sync exactly 1 cycle high; reset_i asserted the cycle after COMMIT -> O_commit_pulse 0, live rules 0.
